// File: rtl/roberto_pkg.sv
// rtl/roberto_pkg.sv - shared encodings and constants for the roberto control unit
//
// Contents:
//   tx_state_t   TX FSM state codes (visible on db_estado)
//   rx_state_t   RX FSM state codes (visible on db_estado_rx)
//   tx_ctrl_t    bundle of TX-side control strobes
//   *_DEF        default frame characters
//   slot_load    one-hot command register load for a slot index

package roberto_pkg;

   typedef enum logic [3:0] {
      inicial        = 4'd0,
      preparacao     = 4'd1,
      mede           = 4'd2,
      espera_seg     = 4'd3,
      transmite      = 4'd4,
      espera_tx      = 4'd5,
      proximo_char   = 4'd6,
      proximo_sensor = 4'd7,
      fim_ciclo      = 4'd8
   } tx_state_t;

   typedef enum logic [2:0] {
      inicial_rx  = 3'd0,
      espera_byte = 3'd1,
      armazena    = 3'd2,
      incrementa  = 3'd3,
      realinha    = 3'd4
   } rx_state_t;

   typedef struct packed {
      logic zera_sensor;
      logic zera_serial;
      logic zera_seg;
      logic zera_2;
      logic zera_3;
      logic zera_recpcao;
      logic zera_servos;
      logic cont_seg;
      logic cont_2;
      logic cont_3;
      logic medir;
      logic partida_tx;
   } tx_ctrl_t;

   localparam logic [6:0] SYNC_CHAR_DEF = 7'h23;
   localparam logic [6:0] MIN_CMD_DEF   = 7'h30;
   localparam logic [6:0] MAX_CMD_DEF   = 7'h33;

   localparam int NUM_SENSORS      = 3;
   localparam int CHARS_PER_SENSOR = 4;
   localparam int NUM_SLOTS        = 3;

   localparam logic [1:0] LAST_SENSOR = 2'(NUM_SENSORS - 1);
   localparam logic [1:0] LAST_CHAR   = 2'(CHARS_PER_SENSOR - 1);
   localparam logic [1:0] LAST_SLOT   = 2'(NUM_SLOTS - 1);

   // Bit 0 drives carrega_reg_1; slot 3 has no register and loads nothing.
   function automatic logic [2:0] slot_load(input logic [1:0] slot);
      logic [2:0] load;
      case (slot)
         2'd0:    load = 3'b001;
         2'd1:    load = 3'b010;
         2'd2:    load = 3'b100;
         default: load = 3'b000;
      endcase
      return load;
   endfunction

endpackage

// File: rtl/roberto_uc.sv
// rtl/roberto_uc.sv - roberto control unit: measurement/transmit FSM and command receive FSM
//
// Inputs:
//   clock, reset (sync, active-high), ligar (enable)
//   pronto_seg, pronto_serial        window end / transmitter done
//   pronto_recepcao, recepcao_serial receiver valid (level or pulse) and byte
//   Q_2, Q_3, Q_recepcao             datapath counter values
// Outputs:
//   zera_*                           synchronous clears for the datapath
//   cont_seg, cont_2, cont_3, cont_recepcao  counter enables
//   medir, partida_tx                measurement trigger, transmitter start
//   carrega_reg_1..3                 command register loads
//   db_estado, db_estado_rx          current TX / RX state codes

module roberto_uc
   import roberto_pkg::*;
#(
   parameter logic [6:0] SYNC_CHAR = SYNC_CHAR_DEF,
   parameter logic [6:0] MIN_CMD   = MIN_CMD_DEF,
   parameter logic [6:0] MAX_CMD   = MAX_CMD_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ligar,
   input  logic       pronto_seg,
   input  logic       pronto_serial,
   input  logic       pronto_recepcao,
   input  logic [6:0] recepcao_serial,
   input  logic [1:0] Q_2,
   input  logic [1:0] Q_3,
   input  logic [1:0] Q_recepcao,
   output logic       zera_sensor,
   output logic       zera_serial,
   output logic       zera_seg,
   output logic       zera_2,
   output logic       zera_3,
   output logic       zera_recpcao,
   output logic       zera_servos,
   output logic       cont_seg,
   output logic       cont_2,
   output logic       cont_3,
   output logic       cont_recepcao,
   output logic       medir,
   output logic       partida_tx,
   output logic       carrega_reg_1,
   output logic       carrega_reg_2,
   output logic       carrega_reg_3,
   output logic [3:0] db_estado,
   output logic [2:0] db_estado_rx
);

   tx_state_t  tx_state;
   tx_state_t  tx_next;
   rx_state_t  rx_state;
   rx_state_t  rx_next;
   tx_ctrl_t   tx_ctrl;
   logic [2:0] load;
   logic       cont_rx;
   logic       pronto_recepcao_d;
   logic       byte_rise;
   logic       byte_is_sync;
   logic       byte_is_cmd;

   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state          <= inicial;
         rx_state          <= inicial_rx;
         pronto_recepcao_d <= 1'b0;
      end else begin
         tx_state          <= tx_next;
         rx_state          <= rx_next;
         pronto_recepcao_d <= pronto_recepcao;
      end
   end

   // A level held for many cycles yields a single rise, so one byte is taken once.
   assign byte_rise    = pronto_recepcao & ~pronto_recepcao_d;
   assign byte_is_sync = (recepcao_serial == SYNC_CHAR);
   assign byte_is_cmd  = (recepcao_serial >= MIN_CMD) && (recepcao_serial <= MAX_CMD);

   // TX: trigger measurement, wait for the window, then stream 3 x 4 characters.
   always_comb begin
      tx_next = tx_state;
      tx_ctrl = '0;
      case (tx_state)
         inicial: begin
            tx_ctrl.zera_sensor  = 1'b1;
            tx_ctrl.zera_serial  = 1'b1;
            tx_ctrl.zera_seg     = 1'b1;
            tx_ctrl.zera_2       = 1'b1;
            tx_ctrl.zera_3       = 1'b1;
            tx_ctrl.zera_recpcao = 1'b1;
            tx_ctrl.zera_servos  = 1'b1;
            tx_next              = preparacao;
         end
         preparacao: begin
            tx_ctrl.zera_seg = 1'b1;
            tx_ctrl.zera_2   = 1'b1;
            tx_ctrl.zera_3   = 1'b1;
            tx_next          = mede;
         end
         mede: begin
            tx_ctrl.medir = 1'b1;
            tx_next       = espera_seg;
         end
         espera_seg: begin
            tx_ctrl.cont_seg = 1'b1;
            if (pronto_seg) begin
               tx_next = transmite;
            end
         end
         transmite: begin
            tx_ctrl.partida_tx = 1'b1;
            tx_next            = espera_tx;
         end
         espera_tx: begin
            if (pronto_serial) begin
               tx_next = proximo_char;
            end
         end
         proximo_char: begin
            // Q_3 is the pre-increment value: 3 means the last character just went out.
            tx_ctrl.cont_3 = 1'b1;
            tx_next        = (Q_3 == LAST_CHAR) ? proximo_sensor : transmite;
         end
         proximo_sensor: begin
            tx_ctrl.cont_2 = 1'b1;
            tx_ctrl.zera_3 = 1'b1;
            tx_next        = (Q_2 == LAST_SENSOR) ? fim_ciclo : transmite;
         end
         fim_ciclo: begin
            tx_ctrl.zera_seg = 1'b1;
            tx_ctrl.zera_2   = 1'b1;
            tx_ctrl.zera_3   = 1'b1;
            tx_next          = mede;
         end
         default: begin
            tx_next = inicial;
         end
      endcase
      if (!ligar) begin
         tx_next = inicial;
      end
   end

   // RX: accept command bytes into slots 1..3; '#' realigns the slot counter to 0.
   always_comb begin
      rx_next = rx_state;
      load    = 3'b000;
      cont_rx = 1'b0;
      case (rx_state)
         inicial_rx: begin
            rx_next = espera_byte;
         end
         espera_byte: begin
            if (byte_rise) begin
               if (byte_is_sync) begin
                  rx_next = realinha;
               end else if (byte_is_cmd) begin
                  rx_next = armazena;
               end
            end
         end
         armazena: begin
            // Slot 3 should be unreachable; recover by realigning without a load.
            if (Q_recepcao == 2'd3) begin
               rx_next = realinha;
            end else begin
               load    = slot_load(Q_recepcao);
               rx_next = incrementa;
            end
         end
         incrementa: begin
            cont_rx = 1'b1;
            rx_next = (Q_recepcao == LAST_SLOT) ? realinha : espera_byte;
         end
         realinha: begin
            // Count the 2-bit slot counter forward until it wraps back to 0.
            cont_rx = (Q_recepcao != 2'd0);
            if (Q_recepcao == 2'd0) begin
               rx_next = espera_byte;
            end
         end
         default: begin
            rx_next = inicial_rx;
         end
      endcase
      if (!ligar) begin
         rx_next = inicial_rx;
      end
   end

   assign zera_sensor   = tx_ctrl.zera_sensor;
   assign zera_serial   = tx_ctrl.zera_serial;
   assign zera_seg      = tx_ctrl.zera_seg;
   assign zera_2        = tx_ctrl.zera_2;
   assign zera_3        = tx_ctrl.zera_3;
   assign zera_recpcao  = tx_ctrl.zera_recpcao;
   assign zera_servos   = tx_ctrl.zera_servos;
   assign cont_seg      = tx_ctrl.cont_seg;
   assign cont_2        = tx_ctrl.cont_2;
   assign cont_3        = tx_ctrl.cont_3;
   assign medir         = tx_ctrl.medir;
   assign partida_tx    = tx_ctrl.partida_tx;
   assign cont_recepcao = cont_rx;
   assign carrega_reg_1 = load[0];
   assign carrega_reg_2 = load[1];
   assign carrega_reg_3 = load[2];
   assign db_estado     = tx_state;
   assign db_estado_rx  = rx_state;

endmodule

// File: tb/tb_roberto_uc.sv
// tb/tb_roberto_uc.sv - self-checking bench for roberto_uc

module tb_roberto_uc;

   logic       clock = 1'b0;
   logic       reset;
   logic       ligar;
   logic       pronto_seg;
   logic       pronto_serial;
   logic       pronto_recepcao;
   logic [6:0] recepcao_serial;
   logic [1:0] q2 = 2'd0;
   logic [1:0] q3 = 2'd0;
   logic [1:0] qr = 2'd0;
   logic       zera_sensor, zera_serial, zera_seg, zera_2, zera_3, zera_recpcao, zera_servos;
   logic       cont_seg, cont_2, cont_3, cont_recepcao, medir, partida_tx;
   logic       carrega_reg_1, carrega_reg_2, carrega_reg_3;
   logic [3:0] db_estado;
   logic [2:0] db_estado_rx;

   logic       ser_auto  = 1'b0;
   logic       ser_stray = 1'b0;
   int         ser_cnt   = 0;
   assign pronto_serial = ser_auto | ser_stray;

   int checks   = 0;
   int failures = 0;

   roberto_uc dut (
      .clock(clock), .reset(reset), .ligar(ligar),
      .pronto_seg(pronto_seg), .pronto_serial(pronto_serial),
      .pronto_recepcao(pronto_recepcao), .recepcao_serial(recepcao_serial),
      .Q_2(q2), .Q_3(q3), .Q_recepcao(qr),
      .zera_sensor(zera_sensor), .zera_serial(zera_serial), .zera_seg(zera_seg),
      .zera_2(zera_2), .zera_3(zera_3), .zera_recpcao(zera_recpcao), .zera_servos(zera_servos),
      .cont_seg(cont_seg), .cont_2(cont_2), .cont_3(cont_3), .cont_recepcao(cont_recepcao),
      .medir(medir), .partida_tx(partida_tx),
      .carrega_reg_1(carrega_reg_1), .carrega_reg_2(carrega_reg_2), .carrega_reg_3(carrega_reg_3),
      .db_estado(db_estado), .db_estado_rx(db_estado_rx)
   );

   always #5 clock = ~clock;

   // Datapath counters that the control unit steers.
   always @(posedge clock) begin
      if (zera_2 === 1'b1) q2 <= 2'd0; else if (cont_2 === 1'b1) q2 <= q2 + 2'd1;
      if (zera_3 === 1'b1) q3 <= 2'd0; else if (cont_3 === 1'b1) q3 <= q3 + 2'd1;
      if (zera_recpcao === 1'b1) qr <= 2'd0; else if (cont_recepcao === 1'b1) qr <= qr + 2'd1;
   end

   // Transmitter stand-in: done pulse 5 cycles after each start.
   always @(negedge clock) begin
      ser_auto = 1'b0;
      if (ser_cnt > 0) begin
         ser_cnt--;
         if (ser_cnt == 0) ser_auto = 1'b1;
      end
      if (partida_tx === 1'b1) ser_cnt = 5;
   end

   wire [15:0] dut_ctrl = {zera_sensor, zera_serial, zera_seg, zera_2, zera_3, zera_recpcao,
                           zera_servos, cont_seg, cont_2, cont_3, cont_recepcao, medir,
                           partida_tx, carrega_reg_1, carrega_reg_2, carrega_reg_3};
   wire [2:0]  loads = {carrega_reg_1, carrega_reg_2, carrega_reg_3};

   // Event logs.
   logic [7:0] tx_log[$];
   int n_cont_rx = 0;
   int n_loads   = 0;
   int n_medir   = 0;
   always @(negedge clock) begin
      if (partida_tx === 1'b1) tx_log.push_back({2'b00, q2, 2'b00, q3});
      if (cont_recepcao === 1'b1) n_cont_rx++;
      if ((carrega_reg_1 | carrega_reg_2 | carrega_reg_3) === 1'b1) n_loads++;
      if (medir === 1'b1) n_medir++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: state codes straight from the transition rules.
   int m_tx = 0;
   int m_rx = 0;
   bit m_prev = 1'b0;
   bit m_valid = 1'b0;

   function automatic int tx_rule(int s, bit lig, bit pseg, bit pser, int a2, int a3);
      if (!lig) return 0;
      case (s)
         0: return 1;
         1: return 2;
         2: return 3;
         3: return pseg ? 4 : 3;
         4: return 5;
         5: return pser ? 6 : 5;
         6: return (a3 == 3) ? 7 : 4;
         7: return (a2 == 2) ? 8 : 4;
         8: return 2;
         default: return 0;
      endcase
   endfunction

   function automatic int rx_rule(int s, bit lig, bit rise, int b, int a);
      if (!lig) return 0;
      case (s)
         0: return 1;
         1: begin
            if (!rise) return 1;
            if (b == 'h23) return 4;
            if (b >= 'h30 && b <= 'h33) return 2;
            return 1;
         end
         2: return (a == 3) ? 4 : 3;
         3: return (a == 2) ? 4 : 1;
         4: return (a == 0) ? 1 : 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [15:0] exp_ctrl(int t, int r, int a);
      bit z_all, z_cnt, z3, crx;
      z_all = (t == 0);
      z_cnt = (t == 0) || (t == 1) || (t == 8);
      z3    = z_cnt || (t == 7);
      crx   = (r == 3) || (r == 4 && a != 0);
      return {z_all, z_all, z_cnt, z_cnt, z3, z_all, z_all, t == 3, t == 7, t == 6, crx,
              t == 2, t == 4, (r == 2 && a == 0), (r == 2 && a == 1), (r == 2 && a == 2)};
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_tx <= 0; m_rx <= 0; m_prev <= 1'b0; m_valid <= 1'b1;
      end else if (m_valid) begin
         m_tx   <= tx_rule(m_tx, ligar, pronto_seg, pronto_serial, int'(q2), int'(q3));
         m_rx   <= rx_rule(m_rx, ligar, pronto_recepcao && !m_prev, int'(recepcao_serial), int'(qr));
         m_prev <= pronto_recepcao;
      end
   end

   always @(negedge clock) begin
      if (m_valid) begin
         check("model_state", {25'd0, db_estado, db_estado_rx}, {25'd0, m_tx[3:0], m_rx[2:0]});
         check("model_ctrl", {16'd0, dut_ctrl}, {16'd0, exp_ctrl(m_tx, m_rx, int'(qr))});
      end
   end

   task automatic wait_tx(input int code, input int limit, input string name);
      int n = 0;
      while (db_estado !== code[3:0] && n < limit) begin
         @(negedge clock);
         n++;
      end
      check(name, {28'd0, db_estado}, code);
   endtask

   task automatic send_byte(input logic [6:0] b, input int hold, input int gap);
      recepcao_serial = b;
      pronto_recepcao = 1'b1;
      repeat (hold) @(negedge clock);
      pronto_recepcao = 1'b0;
      repeat (gap) @(negedge clock);
   endtask

   task automatic rx_load_check(input logic [6:0] b, input logic [2:0] exp, input string name);
      recepcao_serial = b;
      pronto_recepcao = 1'b1;
      @(negedge clock);
      check(name, {29'd0, loads}, {29'd0, exp});
      pronto_recepcao = 1'b0;
      @(negedge clock);
      check({name, "_one_cycle"}, {29'd0, loads}, 0);
      repeat (4) @(negedge clock);
   endtask

   logic [7:0] burst_seq [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11,
                                  8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};

   initial begin
      int snap;
      reset = 1'b1; ligar = 1'b0; pronto_seg = 1'b0;
      pronto_recepcao = 1'b0; recepcao_serial = 7'd0;
      repeat (3) @(negedge clock);
      check("rst_db_estado", {28'd0, db_estado}, 0);
      check("rst_db_estado_rx", {29'd0, db_estado_rx}, 0);
      check("rst_ctrl", {16'd0, dut_ctrl}, 32'h0000_FE00);

      reset = 1'b0; ligar = 1'b1;
      repeat (4) @(negedge clock);
      check("idle_espera_seg", {28'd0, db_estado}, 3);
      check("idle_espera_byte", {29'd0, db_estado_rx}, 1);

      ser_stray = 1'b1;
      @(negedge clock);
      ser_stray = 1'b0;
      @(negedge clock);
      check("stray_serial_ignored", {28'd0, db_estado}, 3);

      // Window end and a sync byte in the same cycle; '#' at slot 0 realigns in one cycle.
      tx_log.delete();
      snap = n_medir;
      pronto_seg = 1'b1; pronto_recepcao = 1'b1; recepcao_serial = 7'h23;
      @(negedge clock);
      pronto_seg = 1'b0; pronto_recepcao = 1'b0;
      check("both_tx_transmite", {28'd0, db_estado}, 4);
      check("both_rx_realinha", {29'd0, db_estado_rx}, 4);
      @(negedge clock);
      check("realinha_q0_exit", {29'd0, db_estado_rx}, 1);

      wait_tx(8, 400, "burst_reach_fim_ciclo");
      check("burst_partida_count", tx_log.size(), 12);
      for (int i = 0; i < 12 && i < tx_log.size(); i++)
         check($sformatf("burst_q_seq_%0d", i), {24'd0, tx_log[i]}, {24'd0, burst_seq[i]});
      @(negedge clock);
      check("fim_to_mede", {28'd0, db_estado}, 2);
      check("medir_pulse", {31'd0, medir}, 1);
      @(negedge clock);
      check("medir_one_cycle", {31'd0, medir}, 0);
      check("medir_once_per_burst", n_medir - snap, 1);

      // RX: '2','0','3' into slots 1,2,3.
      rx_load_check(7'h32, 3'b100, "load_reg1");
      rx_load_check(7'h30, 3'b010, "load_reg2");
      recepcao_serial = 7'h33;
      pronto_recepcao = 1'b1;
      @(negedge clock);
      check("load_reg3", {29'd0, loads}, 32'b001);
      pronto_recepcao = 1'b0;
      repeat (3) @(negedge clock);
      check("q_rx_wrapped", {30'd0, qr}, 0);
      @(negedge clock);
      check("rx_ready_after_wrap", {29'd0, db_estado_rx}, 1);

      // '1', 'x', '#', '3'
      rx_load_check(7'h31, 3'b100, "seq2_load_reg1");
      snap = n_loads;
      send_byte(7'h78, 1, 4);
      send_byte(7'h2F, 1, 4);
      send_byte(7'h34, 1, 4);
      check("junk_discarded", n_loads - snap, 0);
      check("junk_q_kept", {30'd0, qr}, 1);
      snap = n_cont_rx;
      send_byte(7'h23, 1, 6);
      check("realign_from_q1_pulses", n_cont_rx - snap, 3);
      check("realign_q_zero", {30'd0, qr}, 0);
      rx_load_check(7'h33, 3'b100, "after_sync_reg1");

      // Held level counts once; slot 1 -> carrega_reg_2.
      snap = n_loads;
      send_byte(7'h31, 10, 6);
      check("held_level_one_load", n_loads - snap, 1);
      check("held_level_q", {30'd0, qr}, 2);

      // ligar dropped while waiting on the transmitter.
      pronto_seg = 1'b1;
      @(negedge clock);
      pronto_seg = 1'b0;
      wait_tx(5, 50, "reach_espera_tx");
      ligar = 1'b0;
      @(negedge clock);
      check("ligar_off_db_estado", {28'd0, db_estado}, 0);
      check("ligar_off_db_estado_rx", {29'd0, db_estado_rx}, 0);
      check("ligar_off_ctrl", {16'd0, dut_ctrl}, 32'h0000_FE00);
      ligar = 1'b1;
      repeat (10) @(negedge clock);

      // Reset in the middle of a burst.
      tx_log.delete();
      pronto_seg = 1'b1;
      @(negedge clock);
      pronto_seg = 1'b0;
      for (int n = 0; n < 200 && tx_log.size() < 6; n++) @(negedge clock);
      check("midburst_reached", tx_log.size() >= 6, 1);
      reset = 1'b1;
      @(negedge clock);
      check("midrst_db_estado", {28'd0, db_estado}, 0);
      check("midrst_db_estado_rx", {29'd0, db_estado_rx}, 0);
      check("midrst_ctrl", {16'd0, dut_ctrl}, 32'h0000_FE00);
      reset = 1'b0;
      repeat (10) @(negedge clock);
      tx_log.delete();
      pronto_seg = 1'b1;
      @(negedge clock);
      pronto_seg = 1'b0;
      for (int n = 0; n < 20 && tx_log.size() < 1; n++) @(negedge clock);
      check("restart_seen", tx_log.size() > 0, 1);
      if (tx_log.size() > 0) check("restart_q_zero", {24'd0, tx_log[0]}, 0);
      repeat (5) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
